hazard_ctrl_p: RTL and testbench
================================

# hazard_ctrl_p

Parametrised hazard, forwarding and pipeline-control unit for the 5-stage MIPS core. It replaces the single-cycle load-stall controller and adds several behaviours: selectable WB-stage forwarding, a multi-cycle EXE unit (mul/div) with a busy FSM, memory wait-state handshaking, branch flush, and saturating stall/flush performance counters. It sits beside the decoder and drives the stage enable/reset lines and the operand-forwarding muxes.

## Interface
- REG_AW, 5: register address width.
- MD_LAT, 4: EXE occupancy in cycles of an instruction with md_start=1. Must be at least 1; 1 disables the mul/div stall.
- WB_FWD, 1: 1 enables WB-stage forwarding (select 4); 0 means the register file resolves write-before-read.
- CNT_W, 16: performance counter width.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- debug_en, debug_step  in  1 each  debug hold / step request (DEBUG_STEP_EN only).
- id_rs_addr, id_rt_addr  in  REG_AW  source registers of the instruction in ID.
- id_rs_used, id_rt_used, id_is_store  in  1 each  source-use flags for the ID instruction.
- exe_valid, exe_wen, exe_is_load, md_start  in  1 each  EXE stage status.
- exe_waddr  in  REG_AW  EXE stage destination register.
- branch_taken  in  1  branch/jump resolved as taken in EXE.
- mem_valid, mem_wen, mem_is_load, mem_is_store, mem_ready  in  1 each  MEM stage status and data-memory ready.
- mem_waddr  in  REG_AW  MEM stage destination register.
- wb_wen  in  1  WB stage write enable.
- wb_waddr  in  REG_AW  WB stage destination register.
- if_en/if_rst, id_en/id_rst, exe_en/exe_rst, mem_en/mem_rst, wb_en/wb_rst  out  1 each  stage control.
- fwd_a_sel, fwd_b_sel  out  3  forwarding selects: 0 REG, 1 EXE_ALU, 2 MEM_ALU, 3 MEM_DM, 4 WB.
- mem_fwd_store  out  1  forward MEM load data into the store-data path.
- md_busy  out  1  mul/div unit occupying EXE.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- A source matches a stage when all of these hold: the source's used flag is set, the stage's wen is set, the stage's waddr equals the source address, and the address is non-zero.
- Forwarding selects, per source, by priority (youngest first):
  - EXE match with no load → 1.
  - MEM match, mem_is_load=1 → 3.
  - MEM match, mem_is_load=0 → 2.
  - WB match with WB_FWD=1 → 4.
  - Otherwise → 0.
- load_stall: an EXE match on exe_is_load=1 for rs, or for rt when id_is_store=0.
- Store exception: an rt match with id_is_store=1 and exe_is_load=1 produces no stall. Instead mem_fwd_store=1 and fwd_b_sel=0.
- mem_wait = mem_valid & (mem_is_load | mem_is_store) & ~mem_ready.
- Stage-control priority, highest first. The default is every en=1 and every rst=0.
  1. rst: all *_rst=1.
  2. Debug hold: all *_en=0.
  3. mem_wait: if/id/exe/mem_en=0, wb_rst=1.
  4. md_busy: if/id/exe_en=0, mem_rst=1.
  5. branch_taken: id_rst=1, exe_rst=1. This overrides load_stall because the stalled instruction is wrong-path.
  6. load_stall: if_en=0, id_en=0, exe_rst=1.
- Mul/div FSM states are IDLE, RUN and DONE, with a counter of width $clog2(MD_LAT).
  - IDLE → RUN when exe_valid & md_start & ~mem_wait & MD_LAT>1. The counter loads MD_LAT-2. md_busy=1 combinationally in this cycle.
  - RUN: md_busy=1. The counter decrements only while ~mem_wait. At count 0 the FSM moves to DONE.
  - DONE: md_busy=0 and the instruction leaves EXE. The FSM then returns to IDLE. DONE is never entered twice for one instruction.
- Counters saturate at all-ones.
  - stall_cnt increments each cycle with ~rst & ~if_en, excluding debug hold.
  - flush_cnt increments each cycle branch_taken is honoured, i.e. no higher-priority condition applies.

## Timing
- Stage control and forwarding outputs are combinational from current inputs and state. FSM and counters update on the posedge clk.
- Reset values: every *_rst=1, every *_en=1, fwd_*_sel=0, mem_fwd_store=0, md_busy=0, FSM=IDLE, stall_cnt=0, flush_cnt=0.
- Reset mid-RUN aborts the operation: the FSM goes to IDLE next cycle.
- Load-use stall: exactly 1 bubble.
- Mul/div: EXE occupancy is exactly MD_LAT cycles, plus one cycle per mem_wait cycle.
- mem_wait holds the pipeline for as many cycles as mem_ready stays low. Release happens in the cycle mem_ready=1.
- branch_taken together with md_busy: md_busy wins. The flush is applied in the DONE cycle.

## Configuration
- DEBUG_STEP_EN defined: debug_en and debug_step exist. debug_step is registered to debug_step_prev.
  - While debug_en=1, the pipeline is held, except in cycles where debug_step & ~debug_step_prev. Those cycles advance exactly one step with normal control.
- DEBUG_STEP_EN undefined: the ports and registers are absent and there is no debug hold.

## Test plan
- Load-use: lw r2 in EXE, add r3,r2,r1 in ID → one cycle of if_en=0, id_en=0, exe_rst=1. Next cycle fwd_a_sel=3. stall_cnt=1.
- Store data: lw r2 in EXE, sw r2,0(r4) in ID → no stall, mem_fwd_store=1, fwd_b_sel=0.
- Priority and r0: EXE writes r5 and MEM writes r5, ID reads r5 → fwd_a_sel=1. With waddr=0 in every stage → fwd_a_sel=0.
- Mul/div: MD_LAT=4, md_start with exe_valid → md_busy=1 for 3 cycles with mem_rst=1, then DONE. mem_ready=0 for 2 cycles inside RUN → occupancy 6 cycles.
- Branch with load stall: branch_taken=1 while load_stall=1 → id_rst=1, exe_rst=1, if_en=1, flush_cnt increments by 1.
- Debug (DEBUG_STEP_EN): debug_en=1 → all en=0. One debug_step rising edge → exactly one cycle with all en=1.

Source files
------------

// File: rtl/hazard_ctrl_p_if.sv
// hazard_ctrl_p_if: pipeline status inputs and stage-control/forwarding outputs of hazard_ctrl_p.
interface hazard_ctrl_p_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic [REG_AW-1:0] id_rs_addr, id_rt_addr, exe_waddr, mem_waddr, wb_waddr;
  logic id_rs_used, id_rt_used, id_is_store;
  logic exe_valid, exe_wen, exe_is_load, md_start, branch_taken;
  logic mem_valid, mem_wen, mem_is_load, mem_is_store, mem_ready, wb_wen;
  logic if_en, if_rst, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst;
  logic [2:0] fwd_a_sel, fwd_b_sel;
  logic mem_fwd_store, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs_addr, id_rt_addr, exe_waddr, mem_waddr, wb_waddr,
    output id_rs_used, id_rt_used, id_is_store,
    output exe_valid, exe_wen, exe_is_load, md_start, branch_taken,
    output mem_valid, mem_wen, mem_is_load, mem_is_store, mem_ready, wb_wen,
    input if_en, if_rst, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst,
    input fwd_a_sel, fwd_b_sel, mem_fwd_store, md_busy, stall_cnt, flush_cnt
  );
  modport slave (
    input id_rs_addr, id_rt_addr, exe_waddr, mem_waddr, wb_waddr,
    input id_rs_used, id_rt_used, id_is_store,
    input exe_valid, exe_wen, exe_is_load, md_start, branch_taken,
    input mem_valid, mem_wen, mem_is_load, mem_is_store, mem_ready, wb_wen,
    output if_en, if_rst, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst,
    output fwd_a_sel, fwd_b_sel, mem_fwd_store, md_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: hazard detection, operand forwarding, mul/div busy FSM and stall/flush counters.
// Optional debug hold/single-step enabled by defining DEBUG_STEP_EN.
module hazard_ctrl_p #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int WB_FWD = 1,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
`ifdef DEBUG_STEP_EN
  input logic debug_en,
  input logic debug_step,
`endif
  hazard_ctrl_p_if.slave h
);
  localparam int CW = MD_LAT > 2 ? $clog2(MD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} md_st_t;
  md_st_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic dbg, mem_wait, hold, md_go, busy, load_stall, st_fwd;
  logic ex_a, mm_a, wb_a, ex_b, mm_b, wb_b;
  logic d, w, b, f, s;
`ifdef DEBUG_STEP_EN
  logic debug_step_prev;
  always_ff @(posedge clk)
    debug_step_prev <= rst ? 1'b0 : debug_step;
  assign dbg = debug_en & ~(debug_step & ~debug_step_prev);
`else
  assign dbg = 1'b0;
`endif
  function automatic logic [2:0] fsel(input logic e, m, wm, e_ld, m_ld);
    return (e & ~e_ld) ? 3'd1 : m ? (m_ld ? 3'd3 : 3'd2) : (wm && WB_FWD != 0) ? 3'd4 : 3'd0;
  endfunction
  assign ex_a = h.id_rs_used & h.exe_wen & (h.exe_waddr == h.id_rs_addr) & (h.id_rs_addr != REG_AW'(0));
  assign mm_a = h.id_rs_used & h.mem_wen & (h.mem_waddr == h.id_rs_addr) & (h.id_rs_addr != REG_AW'(0));
  assign wb_a = h.id_rs_used & h.wb_wen  & (h.wb_waddr  == h.id_rs_addr) & (h.id_rs_addr != REG_AW'(0));
  assign ex_b = h.id_rt_used & h.exe_wen & (h.exe_waddr == h.id_rt_addr) & (h.id_rt_addr != REG_AW'(0));
  assign mm_b = h.id_rt_used & h.mem_wen & (h.mem_waddr == h.id_rt_addr) & (h.id_rt_addr != REG_AW'(0));
  assign wb_b = h.id_rt_used & h.wb_wen  & (h.wb_waddr  == h.id_rt_addr) & (h.id_rt_addr != REG_AW'(0));
  // A store only needs the loaded value in MEM, so it takes the late store-data path instead of stalling.
  assign st_fwd     = ex_b & h.id_is_store & h.exe_is_load;
  assign load_stall = h.exe_is_load & (ex_a | (ex_b & ~h.id_is_store));
  assign h.fwd_a_sel     = rst ? 3'd0 : fsel(ex_a, mm_a, wb_a, h.exe_is_load, h.mem_is_load);
  assign h.fwd_b_sel     = (rst | st_fwd) ? 3'd0 : fsel(ex_b, mm_b, wb_b, h.exe_is_load, h.mem_is_load);
  assign h.mem_fwd_store = ~rst & st_fwd;
  assign mem_wait = h.mem_valid & (h.mem_is_load | h.mem_is_store) & ~h.mem_ready;
  assign hold     = dbg | mem_wait;
  assign md_go    = (st == IDLE) & h.exe_valid & h.md_start & ~hold & (MD_LAT > 1);
  assign busy     = ~rst & (md_go | st == RUN);
  assign h.md_busy = busy;
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    if (md_go) begin
      st_nx  = MD_LAT == 2 ? DONE : RUN;
      cnt_nx = CW'(MD_LAT - 2);
    end else if (st == RUN && !hold) begin
      st_nx  = cnt == CW'(1) ? DONE : RUN;
      cnt_nx = cnt - 1'b1;
    end else if (st == DONE && !hold)
      st_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    st  <= rst ? IDLE : st_nx;
    cnt <= rst ? '0 : cnt_nx;
  end
  // One-hot priority levels: debug hold, memory wait, mul/div busy, flush, load stall.
  assign d = ~rst & dbg;
  assign w = ~rst & ~dbg & mem_wait;
  assign b = ~rst & ~dbg & ~mem_wait & busy;
  assign f = ~rst & ~dbg & ~mem_wait & ~busy & h.branch_taken;
  assign s = ~rst & ~dbg & ~mem_wait & ~busy & ~h.branch_taken & load_stall;
  assign h.if_en   = ~(d | w | b | s);
  assign h.id_en   = ~(d | w | b | s);
  assign h.exe_en  = ~(d | w | b);
  assign h.mem_en  = ~(d | w);
  assign h.wb_en   = ~d;
  assign h.if_rst  = rst;
  assign h.id_rst  = rst | f;
  assign h.exe_rst = rst | f | s;
  assign h.mem_rst = rst | b;
  assign h.wb_rst  = rst | w;
  always_ff @(posedge clk) begin
    if (rst) begin
      h.stall_cnt <= '0;
      h.flush_cnt <= '0;
    end else begin
      if ((w | b | s) && h.stall_cnt != {CNT_W{1'b1}}) h.stall_cnt <= h.stall_cnt + 1'b1;
      if (f && h.flush_cnt != {CNT_W{1'b1}}) h.flush_cnt <= h.flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_p.sv
// tb_hazard_ctrl_p: directed self-checking bench for hazard_ctrl_p (narrow counters to reach saturation).
module tb_hazard_ctrl_p;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  hazard_ctrl_p_if #(.REG_AW(5), .CNT_W(4)) h ();
`ifdef DEBUG_STEP_EN
  logic debug_en, debug_step;
  hazard_ctrl_p #(.REG_AW(5), .MD_LAT(4), .WB_FWD(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step), .h(h));
`else
  hazard_ctrl_p #(.REG_AW(5), .MD_LAT(4), .WB_FWD(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .h(h));
`endif
  logic [9:0] ctrl;
  assign ctrl = {h.if_en, h.id_en, h.exe_en, h.mem_en, h.wb_en,
                 h.if_rst, h.id_rst, h.exe_rst, h.mem_rst, h.wb_rst};
  localparam logic [9:0] NORM = 10'b11111_00000, LSTL = 10'b00111_00100, BRF = 10'b11111_01100,
                         MDB = 10'b00011_00010, MWT = 10'b00001_00001;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {h.id_rs_addr, h.id_rt_addr, h.exe_waddr, h.mem_waddr, h.wb_waddr} = '0;
    {h.id_rs_used, h.id_rt_used, h.id_is_store} = '0;
    {h.exe_valid, h.exe_wen, h.exe_is_load, h.md_start, h.branch_taken} = '0;
    {h.mem_valid, h.mem_wen, h.mem_is_load, h.mem_is_store, h.wb_wen} = '0;
    h.mem_ready = 1'b1;
  endtask
  task automatic id_src(input logic ru, input logic [4:0] ra, input logic tu, input logic [4:0] ta, input logic st);
    h.id_rs_used = ru; h.id_rs_addr = ra; h.id_rt_used = tu; h.id_rt_addr = ta; h.id_is_store = st;
  endtask
  task automatic exe_lw(input logic [4:0] a);
    h.exe_valid = 1'b1; h.exe_wen = 1'b1; h.exe_is_load = 1'b1; h.exe_waddr = a;
  endtask
  initial begin
`ifdef DEBUG_STEP_EN
    debug_en = 1'b0; debug_step = 1'b0;
`endif
    clr();
    rst = 1'b1;
    id_src(1, 5, 0, 0, 0); h.exe_wen = 1'b1; h.exe_waddr = 5; h.exe_valid = 1'b1; h.md_start = 1'b1;
    #2;
    chk("rst_ctrl", ctrl, 10'h3FF);
    chk("rst_fwd_a", h.fwd_a_sel, 0);
    chk("rst_md_busy", h.md_busy, 0);
    chk("rst_mem_fwd_store", h.mem_fwd_store, 0);
    step(); step();
    chk("rst_stall_cnt", h.stall_cnt, 0);
    chk("rst_flush_cnt", h.flush_cnt, 0);
    rst = 1'b0; clr(); #1;
    chk("idle_ctrl", ctrl, NORM);
    exe_lw(2); id_src(1, 2, 1, 1, 0); #1;
    chk("lu_ctrl", ctrl, LSTL);
    step(); clr(); id_src(1, 2, 1, 1, 0);
    h.mem_valid = 1'b1; h.mem_wen = 1'b1; h.mem_is_load = 1'b1; h.mem_waddr = 2; #1;
    chk("lu_after_ctrl", ctrl, NORM);
    chk("lu_after_fwd_a", h.fwd_a_sel, 3);
    chk("lu_after_fwd_b", h.fwd_b_sel, 0);
    chk("lu_stall_cnt", h.stall_cnt, 1);
    step(); clr(); exe_lw(2); id_src(1, 4, 1, 2, 1); h.mem_wen = 1'b1; h.mem_waddr = 2; #1;
    chk("st_ctrl", ctrl, NORM);
    chk("st_mem_fwd_store", h.mem_fwd_store, 1);
    chk("st_fwd_b", h.fwd_b_sel, 0);
    chk("st_fwd_a", h.fwd_a_sel, 0);
    h.id_is_store = 1'b0; #1;
    chk("rt_load_ctrl", ctrl, LSTL);
    chk("rt_load_mfs", h.mem_fwd_store, 0);
    h.id_is_store = 1'b1; #1;
    step(); clr(); id_src(1, 5, 1, 5, 0);
    h.exe_wen = 1'b1; h.exe_waddr = 5; h.mem_wen = 1'b1; h.mem_waddr = 5; h.wb_wen = 1'b1; h.wb_waddr = 5; #1;
    chk("pri_exe_a", h.fwd_a_sel, 1);
    chk("pri_exe_b", h.fwd_b_sel, 1);
    h.exe_wen = 1'b0; #1;
    chk("pri_mem_alu", h.fwd_a_sel, 2);
    h.mem_is_load = 1'b1; #1;
    chk("pri_mem_dm", h.fwd_a_sel, 3);
    h.mem_wen = 1'b0; #1;
    chk("pri_wb", h.fwd_a_sel, 4);
    h.id_rs_used = 1'b0; #1;
    chk("pri_unused_a", h.fwd_a_sel, 0);
    chk("pri_wb_b", h.fwd_b_sel, 4);
    clr(); id_src(1, 0, 1, 0, 0); h.exe_wen = 1'b1; h.mem_wen = 1'b1; h.wb_wen = 1'b1; #1;
    chk("r0_fwd_a", h.fwd_a_sel, 0);
    chk("r0_fwd_b", h.fwd_b_sel, 0);
    h.exe_is_load = 1'b1; #1;
    chk("r0_no_stall", ctrl, NORM);
    step(); clr(); exe_lw(2); id_src(1, 2, 0, 0, 0); h.branch_taken = 1'b1; #1;
    chk("br_ctrl", ctrl, BRF);
    step(); clr(); #1;
    chk("br_flush_cnt", h.flush_cnt, 1);
    chk("br_stall_cnt", h.stall_cnt, 1);
    h.mem_valid = 1'b1; h.mem_is_load = 1'b1; h.mem_ready = 1'b0; h.branch_taken = 1'b1; #1;
    chk("mw_ctrl0", ctrl, MWT);
    step();
    chk("mw_ctrl1", ctrl, MWT);
    step(); h.mem_ready = 1'b1; h.branch_taken = 1'b0; #1;
    chk("mw_release", ctrl, NORM);
    chk("mw_stall_cnt", h.stall_cnt, 3);
    chk("mw_flush_cnt", h.flush_cnt, 1);
    step(); clr(); h.exe_valid = 1'b1; h.md_start = 1'b1; h.branch_taken = 1'b1; #1;
    chk("md0_busy", h.md_busy, 1);
    chk("md0_ctrl", ctrl, MDB);
    step();
    chk("md1_busy", h.md_busy, 1);
    chk("md1_ctrl", ctrl, MDB);
    step();
    chk("md2_busy", h.md_busy, 1);
    step();
    chk("md_done_busy", h.md_busy, 0);
    chk("md_done_ctrl", ctrl, BRF);
    step(); clr(); #1;
    chk("md_idle_busy", h.md_busy, 0);
    chk("md_stall_cnt", h.stall_cnt, 6);
    chk("md_flush_cnt", h.flush_cnt, 2);
    h.exe_valid = 1'b1; h.md_start = 1'b1; #1;
    chk("mdw0_busy", h.md_busy, 1);
    step(); h.mem_valid = 1'b1; h.mem_is_store = 1'b1; h.mem_ready = 1'b0; #1;
    chk("mdw1_busy", h.md_busy, 1);
    chk("mdw1_ctrl", ctrl, MWT);
    step();
    chk("mdw2_busy", h.md_busy, 1);
    step(); h.mem_ready = 1'b1; #1;
    chk("mdw3_ctrl", ctrl, MDB);
    step();
    chk("mdw4_busy", h.md_busy, 1);
    step();
    chk("mdw5_busy", h.md_busy, 0);
    chk("mdw5_ctrl", ctrl, NORM);
    step(); clr(); #1;
    chk("mdw_stall_cnt", h.stall_cnt, 11);
    h.exe_valid = 1'b1; h.md_start = 1'b1; #1;
    step(); h.exe_valid = 1'b0; h.md_start = 1'b0; #1;
    chk("rr_run_busy", h.md_busy, 1);
    rst = 1'b1; #1;
    chk("rr_rst_busy", h.md_busy, 0);
    chk("rr_rst_ctrl", ctrl, 10'h3FF);
    step(); rst = 1'b0; #1;
    chk("rr_idle_busy", h.md_busy, 0);
    chk("rr_stall_cnt", h.stall_cnt, 0);
    exe_lw(3); id_src(0, 0, 1, 3, 0); #1;
    repeat (20) step();
    chk("sat_ctrl", ctrl, LSTL);
    chk("sat_stall_cnt", h.stall_cnt, 15);
    clr(); #1;
`ifdef DEBUG_STEP_EN
    debug_en = 1'b1; #1;
    chk("dbg_hold", ctrl, 10'b0);
    step(); debug_step = 1'b1; #1;
    chk("dbg_step", ctrl, NORM);
    step();
    chk("dbg_hold2", ctrl, 10'b0);
    chk("dbg_stall_cnt", h.stall_cnt, 15);
    debug_en = 1'b0; debug_step = 1'b0; #1;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
